prefetch_queue: RTL and testbench

- Bus interface and instruction prefetch stage that sits directly upstream of the 1 MB byte SRAM and downstream of the x86 execution unit (EU).
- It owns the single SRAM port (address, data_out, write_ena, data_in). It fetches code bytes at CS:IP into a small FIFO for the decoder.
- EU data reads and writes take priority over code fetch.
- SRAM read timing: address and write_ena are sampled at a clock edge; data_in for that address is valid during the following cycle.

---
 rtl/x86_pkg.sv | 15 +
 rtl/byte_fifo.sv | 53 +++++
 rtl/prefetch_queue.sv | 105 ++++++++++
 tb/tb_prefetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/x86_pkg.sv
// Shared x86 bus constants and real-mode segment:offset address formation.
package x86_pkg;

    localparam int ADDR_W = 20;

    localparam logic [15:0] RESET_CS = 16'hFFFF;
    localparam logic [15:0] RESET_IP = 16'h0000;

    // Carry out of bit 19 is dropped, so FFFF:0010 lands on 00000.
    function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] seg,
                                                     input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with clear; holds prefetched code bytes for the decoder.
module byte_fifo #(
    parameter int DEPTH = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   push_data,
    output logic [7:0]                   head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (push && !clear)
            mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/prefetch_queue.sv
// Bus interface unit: arbitrates the single SRAM port between EU accesses and
// code prefetch at CS:IP, feeding fetched bytes into a small queue.
module prefetch_queue
    import x86_pkg::*;
#(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_CS = x86_pkg::RESET_CS,
    parameter logic [15:0] RESET_IP = x86_pkg::RESET_IP
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              write_ena,
    input  logic              flush,
    input  logic [15:0]       flush_cs,
    input  logic [15:0]       flush_ip,
    output logic              q_valid,
    output logic [7:0]        q_byte,
    output logic [15:0]       q_ip,
    input  logic              q_pop,
    input  logic              eu_req,
    input  logic              eu_we,
    input  logic [ADDR_W-1:0] eu_addr,
    input  logic [7:0]        eu_wdata,
    output logic              eu_ack,
    output logic [7:0]        eu_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [15:0]      cs;
    logic [15:0]      fetch_ip;
    logic [15:0]      head_ip;
    logic             fetch_inflight;
    logic             eu_inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             eu_slot;
    logic             fetch_slot;
    logic             push;
    logic             pop;

    // Bytes already queued plus the one on its way back must leave room.
    assign occupancy  = {1'b0, count} + (CNT_W + 1)'(fetch_inflight);
    assign eu_slot    = !flush && eu_req && !eu_inflight;
    assign fetch_slot = !flush && !eu_slot && (occupancy < (CNT_W + 1)'(DEPTH));

    always_comb begin
        address   = '0;
        data_out  = '0;
        write_ena = 1'b0;
        if (eu_slot) begin
            address   = eu_addr;
            data_out  = eu_wdata;
            write_ena = eu_we;
        end else if (fetch_slot) begin
            address = phys_addr(cs, fetch_ip);
        end
    end

    assign push     = fetch_inflight && !flush;
    assign pop      = q_pop && q_valid && !flush;
    assign q_valid  = (count != '0);
    assign q_ip     = head_ip;
    assign eu_ack   = eu_inflight;
    assign eu_rdata = data_in;

    // Flush leaves eu_inflight alone so a started EU access still acks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs             <= RESET_CS;
            fetch_ip       <= RESET_IP;
            head_ip        <= RESET_IP;
            fetch_inflight <= 1'b0;
            eu_inflight    <= 1'b0;
        end else begin
            fetch_inflight <= fetch_slot;
            eu_inflight    <= eu_slot;
            if (flush) begin
                cs       <= flush_cs;
                fetch_ip <= flush_ip;
                head_ip  <= flush_ip;
            end else begin
                if (fetch_slot) fetch_ip <= fetch_ip + 16'd1;
                if (pop)        head_ip  <= head_ip + 16'd1;
            end
        end
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .pop      (pop),
        .push_data(data_in),
        .head_data(q_byte),
        .count    (count)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a 1 MB SRAM model behind the bus port.
module tb_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] address;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        write_ena;
    logic        flush = 1'b0;
    logic [15:0] flush_cs = 16'h0000;
    logic [15:0] flush_ip = 16'h0000;
    logic        q_valid;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic        q_pop = 1'b0;
    logic        eu_req = 1'b0;
    logic        eu_we = 1'b0;
    logic [19:0] eu_addr = 20'h00000;
    logic [7:0]  eu_wdata = 8'h00;
    logic        eu_ack;
    logic [7:0]  eu_rdata;

    logic [7:0]  mem [0:1048575];
    logic [7:0]  boot [6];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clock = ~clock;

    prefetch_queue #(
        .DEPTH   (6),
        .RESET_CS(16'hFFFF),
        .RESET_IP(16'h0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .write_ena(write_ena),
        .flush    (flush),
        .flush_cs (flush_cs),
        .flush_ip (flush_ip),
        .q_valid  (q_valid),
        .q_byte   (q_byte),
        .q_ip     (q_ip),
        .q_pop    (q_pop),
        .eu_req   (eu_req),
        .eu_we    (eu_we),
        .eu_addr  (eu_addr),
        .eu_wdata (eu_wdata),
        .eu_ack   (eu_ack),
        .eu_rdata (eu_rdata)
    );

    // SRAM: address sampled at the edge, read data valid the following cycle.
    always @(posedge clock) begin
        if (write_ena) mem[address] <= data_out;
        data_in <= mem[address];
    end

    function automatic logic [7:0] pat(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1048576; i++) mem[i] = pat(20'(i));
        boot = '{8'hEA, 8'h00, 8'h01, 8'h00, 8'hF0, 8'h90};
        for (int i = 0; i < 6; i++) mem[20'hFFFF0 + 20'(i)] = boot[i];

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_eu_ack", eu_ack, 0);
        chk("rst_write_ena", write_ena, 0);
        step();
        reset = 1'b0;

        // Boot fetch FFFF0..FFFF5, then stall with a full queue
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("boot_addr", address, 20'hFFFF0 + 20'(i));
            if (i == 2) begin
                chk("boot_q_valid", q_valid, 1);
                chk("boot_q_byte", q_byte, 8'hEA);
                chk("boot_q_ip", q_ip, 16'h0000);
            end
            step();
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk("stall_addr", address, 20'h00000);
            step();
        end
        @(negedge clock);
        chk("full_q_byte", q_byte, 8'hEA);
        chk("full_q_ip", q_ip, 16'h0000);

        // Continuous pop from a full queue
        step();
        q_pop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("pop_q_valid", q_valid, 1);
            chk("pop_q_ip", q_ip, 32'(k));
            chk("pop_q_byte", q_byte, (k < 6) ? boot[k] : pat(20'hFFFF0 + 20'(k)));
            step();
        end
        q_pop = 1'b0;

        // Flush to FFFF:0010 wraps to physical 00000
        flush = 1'b1; flush_cs = 16'hFFFF; flush_ip = 16'h0010;
        @(negedge clock);
        chk("flush_idle_we", write_ena, 0);
        chk("flush_idle_addr", address, 20'h00000);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("wrap_addr0", address, 20'h00000);
        step();
        @(negedge clock);
        chk("wrap_addr1", address, 20'h00001);
        chk("wrap_q_valid0", q_valid, 0);
        step();
        @(negedge clock);
        chk("wrap_q_valid1", q_valid, 1);
        chk("wrap_q_ip", q_ip, 16'h0010);
        chk("wrap_q_byte", q_byte, pat(20'h00000));

        // Flush during the return cycle of a fetch from 12345
        step();
        flush = 1'b1; flush_cs = 16'h1234; flush_ip = 16'h0005;
        @(negedge clock);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("cancel_issue", address, 20'h12345);
        step();
        flush = 1'b1; flush_cs = 16'h2000; flush_ip = 16'h0100;
        @(negedge clock);
        chk("cancel_q_valid_a", q_valid, 0);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("cancel_q_valid_b", q_valid, 0);
        chk("cancel_new_addr", address, 20'h20100);
        step();
        @(negedge clock);
        chk("cancel_q_valid_c", q_valid, 0);
        step();
        @(negedge clock);
        chk("cancel_q_valid_d", q_valid, 1);
        chk("cancel_q_ip", q_ip, 16'h0100);
        chk("cancel_q_byte", q_byte, pat(20'h20100));

        // EU write while fetching
        step();
        eu_req = 1'b1; eu_we = 1'b1; eu_addr = 20'h00400; eu_wdata = 8'h5A;
        @(negedge clock);
        chk("euw_we", write_ena, 1);
        chk("euw_addr", address, 20'h00400);
        chk("euw_data", data_out, 8'h5A);
        chk("euw_ack_early", eu_ack, 0);
        step();
        @(negedge clock);
        chk("euw_ack", eu_ack, 1);
        chk("euw_we_done", write_ena, 0);
        chk("euw_resume_addr", address, 20'h20103);
        step();
        eu_req = 1'b0; eu_we = 1'b0;
        @(negedge clock);
        chk("euw_ack_clear", eu_ack, 0);

        // EU read back of 00400
        step();
        eu_req = 1'b1; eu_we = 1'b0; eu_addr = 20'h00400;
        @(negedge clock);
        chk("eur_addr", address, 20'h00400);
        chk("eur_we", write_ena, 0);
        step();
        @(negedge clock);
        chk("eur_ack", eu_ack, 1);
        chk("eur_rdata", eu_rdata, 8'h5A);
        step();
        eu_req = 1'b0;

        // Queue contents stayed contiguous across the EU accesses
        q_pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("cont_q_ip", q_ip, 16'h0100 + 16'(k));
            chk("cont_q_byte", q_byte, pat(20'h20100 + 20'(k)));
            step();
        end
        q_pop = 1'b0;

        // IP wraps within the segment
        flush = 1'b1; flush_cs = 16'h1000; flush_ip = 16'hFFFF;
        @(negedge clock);
        step();
        flush = 1'b0;
        @(negedge clock);
        chk("ipwrap_addr0", address, 20'h1FFFF);
        step();
        @(negedge clock);
        chk("ipwrap_addr1", address, 20'h10000);
        step();
        @(negedge clock);
        chk("ipwrap_q_ip", q_ip, 16'hFFFF);
        chk("ipwrap_q_byte", q_byte, pat(20'h1FFFF));

        // Reset during an EU read return cycle
        step();
        eu_req = 1'b1; eu_we = 1'b0; eu_addr = 20'h00400;
        @(negedge clock);
        chk("rstrd_addr", address, 20'h00400);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("rstrd_eu_ack", eu_ack, 0);
        chk("rstrd_q_valid", q_valid, 0);
        step();
        reset = 1'b0;
        eu_req = 1'b0;
        @(negedge clock);
        chk("rstrd_next_addr", address, 20'hFFFF0);
        chk("rstrd_eu_ack_after", eu_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
